// File: rtl/serial_divisibility_scheduler.sv
// Round-robin front end sharing one bit-serial mod-DIV engine among N_REQ requesters.
// Words enter MSB-first; the remainder is returned with the requester id.
module serial_divisibility_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 16,
  parameter int DIV   = 5,
  parameter int REM_W = $clog2(DIV),
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_id,
  output logic               res_div,
  output logic [REM_W-1:0]   res_rem,
  output logic               busy,
  output logic               ser_bit,
  output logic               ser_en
);
  localparam int CNT_W = $clog2(W+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [ID_W-1:0]  rr_ptr, id, gnt_id;
  logic [ID_W:0]    idx;
  logic             gnt_found, take;
  logic [W-1:0]     word;
  logic [REM_W-1:0] rem, rem_nxt;
  logic [REM_W:0]   rem_x2;
  logic [CNT_W-1:0] cnt;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!gnt_found && req_valid[idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = idx[ID_W-1:0];
      end
    end
  end

  assign take = (state == IDLE) && gnt_found && !rst;

  // 2*rem+bit stays below 2*DIV, so one conditional subtract is enough.
  assign rem_x2  = {rem, word[W-1]};
  assign rem_nxt = (rem_x2 >= (REM_W+1)'(DIV)) ? REM_W'(rem_x2 - (REM_W+1)'(DIV))
                                               : rem_x2[REM_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      id     <= '0;
      word   <= '0;
      rem    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          word   <= req_data[gnt_id*W +: W];
          id     <= gnt_id;
          rem    <= '0;
          cnt    <= CNT_W'(W);
          rr_ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
        SHIFT: begin
          rem  <= rem_nxt;
          word <= {word[W-2:0], 1'b0};
          cnt  <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    res_valid = 1'b0;
    res_id    = '0;
    res_rem   = '0;
    res_div   = 1'b0;
    ser_en    = 1'b0;
    ser_bit   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (take) req_ready = N_REQ'(1) << gnt_id;
      SHIFT: begin
        ser_en  = 1'b1;
        ser_bit = word[W-1];
      end
      DONE: begin
        res_valid = 1'b1;
        res_id    = id;
        res_rem   = rem;
        res_div   = (rem == '0);
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_serial_divisibility_scheduler.sv
// Directed and randomized checks of the shared divisibility scheduler (N_REQ=4, W=16, DIV=5).
module tb_serial_divisibility_scheduler;
  localparam int N_REQ = 4;
  localparam int W     = 16;
  localparam int DIV   = 5;
  localparam int REM_W = 3;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               res_valid, res_ready, res_div, busy, ser_bit, ser_en;
  logic [ID_W-1:0]    res_id;
  logic [REM_W-1:0]   res_rem;

  int n_chk  = 0;
  int n_pass = 0;

  serial_divisibility_scheduler #(.N_REQ(N_REQ), .W(W), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_div(res_div), .res_rem(res_rem), .busy(busy),
    .ser_bit(ser_bit), .ser_en(ser_en)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; req_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({req_ready, res_valid, res_id, res_div, res_rem, busy, ser_bit, ser_en} !== '0)
      $display("FAIL reset_outputs: rdy=%b rv=%b id=%0d div=%b rem=%0d busy=%b sb=%b se=%b, all required 0",
               req_ready, res_valid, res_id, res_div, res_rem, busy, ser_bit, ser_en);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({req_ready, res_valid, busy, ser_en} !== '0)
      $display("FAIL after_reset_idle: rdy=%b rv=%b busy=%b se=%b, required 0", req_ready, res_valid, busy, ser_en);
    else n_pass++;
  endtask

  // One isolated job; entered and left at a negedge with the DUT idle.
  task automatic run_job(input int rid, input logic [W-1:0] data,
                         input logic [REM_W-1:0] exp_rem, input string name);
    int cyc;
    req_valid = N_REQ'(1 << rid);
    req_data[rid*W +: W] = data;
    #1;
    n_chk++;
    if (req_ready !== N_REQ'(1 << rid))
      $display("FAIL %s_grant: req_ready=%b required %b", name, req_ready, N_REQ'(1 << rid));
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    n_chk++;
    if (busy !== 1'b1 || ser_en !== 1'b1 || ser_bit !== data[W-1])
      $display("FAIL %s_shift: busy=%b ser_en=%b ser_bit=%b required 1 1 %b", name, busy, ser_en, ser_bit, data[W-1]);
    else n_pass++;
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    n_chk++;
    if (cyc != W) $display("FAIL %s_latency: %0d cycles required %0d", name, cyc, W);
    else n_pass++;
    n_chk++;
    if (res_valid !== 1'b1 || res_id !== ID_W'(rid) || res_rem !== exp_rem || res_div !== (exp_rem == 0))
      $display("FAIL %s_result: valid=%b id=%0d rem=%0d div=%b required 1 %0d %0d %b",
               name, res_valid, res_id, res_rem, res_div, rid, exp_rem, exp_rem == 0);
    else n_pass++;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    n_chk++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_rem !== '0)
      $display("FAIL %s_release: res_valid=%b busy=%b rem=%0d required 0 0 0", name, res_valid, busy, res_rem);
    else n_pass++;
  endtask

  task automatic test_basic;
    run_job(0, 16'd35,    3'd0, "w35");
    run_job(2, 16'd37,    3'd2, "w37");
    run_job(1, 16'hFFFF,  3'd0, "wffff");
    run_job(0, 16'd0,     3'd0, "w0");
    run_job(3, 16'h8001,  3'd4, "w8001");
  endtask

  task automatic test_round_robin;
    logic [W-1:0] dat [N_REQ];
    int gid[5], gcyc[5];
    int gcount, cyc, last_g;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    dat[0] = 16'd35; dat[1] = 16'hFFFF; dat[2] = 16'd37; dat[3] = 16'd9;
    do_reset();
    for (int i = 0; i < N_REQ; i++) req_data[i*W +: W] = dat[i];
    req_valid = '1;
    res_ready = 1'b1;
    gcount = 0; cyc = 0; last_g = -1;
    while (gcount < 5 && cyc < 300) begin
      #1;
      if (res_valid) begin
        n_chk++;
        if (last_g < 0 || res_id !== ID_W'(last_g) || res_rem !== REM_W'(dat[last_g] % DIV))
          $display("FAIL rr_result: id=%0d rem=%0d required %0d %0d", res_id, res_rem,
                   last_g, (last_g < 0) ? 0 : dat[last_g] % DIV);
        else n_pass++;
      end
      if (req_ready != '0) begin
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) last_g = i;
        gid[gcount] = last_g; gcyc[gcount] = cyc; gcount++;
      end
      if (gcount < 5) begin
        @(posedge clk); cyc++;
        @(negedge clk);
      end
    end
    req_valid = '0;
    res_ready = 1'b0;
    n_chk++;
    if (gcount != 5) $display("FAIL rr_grant_count: %0d grants required 5", gcount);
    else n_pass++;
    for (int k = 0; k < gcount; k++) begin
      n_chk++;
      if (gid[k] != exp_order[k]) $display("FAIL rr_order_%0d: grant %0d required %0d", k, gid[k], exp_order[k]);
      else n_pass++;
      if (k > 0) begin
        n_chk++;
        if (gcyc[k] - gcyc[k-1] != W + 2)
          $display("FAIL rr_spacing_%0d: %0d cycles required %0d", k, gcyc[k] - gcyc[k-1], W + 2);
        else n_pass++;
      end
    end
  endtask

  task automatic test_result_stall;
    int cyc;
    @(negedge clk);
    req_valid = 4'b0001;
    req_data[0 +: W] = 16'd37;
    #1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    req_valid = 4'b1000;
    req_data[3*W +: W] = 16'd12;
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++;
      if (res_valid !== 1'b1 || res_id !== 2'd0 || res_rem !== 3'd2 || res_div !== 1'b0 || req_ready !== 4'b0000)
        $display("FAIL stall_hold_%0d: valid=%b id=%0d rem=%0d div=%b rdy=%b required 1 0 2 0 0000",
                 k, res_valid, res_id, res_rem, res_div, req_ready);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 4'b1000 || res_valid !== 1'b0)
      $display("FAIL stall_regrant: rdy=%b res_valid=%b required 1000 0", req_ready, res_valid);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    n_chk++;
    if (cyc != W || res_id !== 2'd3 || res_rem !== 3'd2)
      $display("FAIL stall_req3_result: cyc=%0d id=%0d rem=%0d required %0d 3 2", cyc, res_id, res_rem, W);
    else n_pass++;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset_abort;
    int seen;
    req_valid = 4'b0010;
    req_data[1*W +: W] = 16'd1001;
    #1;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (ser_en !== 1'b1) $display("FAIL abort_in_shift: ser_en=%b required 1", ser_en);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({req_ready, res_valid, res_id, res_div, res_rem, busy, ser_bit, ser_en} !== '0)
      $display("FAIL abort_outputs: rdy=%b rv=%b rem=%0d busy=%b se=%b, all required 0",
               req_ready, res_valid, res_rem, busy, ser_en);
    else n_pass++;
    rst = 1'b0;
    res_ready = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid) seen++;
    end
    res_ready = 1'b0;
    n_chk++;
    if (seen != 0) $display("FAIL abort_no_result: res_valid seen %0d cycles required 0", seen);
    else n_pass++;
    req_valid = '1;
    #1;
    n_chk++;
    if (req_ready !== 4'b0001) $display("FAIL abort_rr_ptr: req_ready=%b required 0001", req_ready);
    else n_pass++;
    req_valid = '0;
    #1;
    run_job(1, 16'd1001, 3'd1, "rereq");
  endtask

  task automatic test_random;
    logic [W-1:0]     wq [N_REQ];
    logic [N_REQ-1:0] v, exp_rdy;
    logic [W-1:0]     exp_word;
    int m_ptr, exp_id, done_cnt, cyc, g, bad;
    bit in_flight, res_took;
    do_reset();
    v = '0; m_ptr = 0; in_flight = 0; res_took = 0;
    done_cnt = 0; cyc = 0; bad = 0; exp_id = 0; exp_word = '0;
    for (int i = 0; i < N_REQ; i++) wq[i] = '0;
    while (done_cnt < 1000 && cyc < 60000) begin
      if (res_took) begin in_flight = 0; res_took = 0; end
      for (int i = 0; i < N_REQ; i++)
        if (!v[i] && $urandom_range(0, 3) == 0) begin
          v[i] = 1'b1;
          wq[i] = W'($urandom);
        end
      req_valid = v;
      for (int i = 0; i < N_REQ; i++) req_data[i*W +: W] = wq[i];
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = '0; g = -1;
      if (!in_flight)
        for (int k = 0; k < N_REQ; k++)
          if (g < 0 && v[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
      if (g >= 0) exp_rdy = N_REQ'(1 << g);
      n_chk++;
      if (req_ready !== exp_rdy) begin
        if (bad < 20) $display("FAIL rand_grant: cyc=%0d req_ready=%b required %b", cyc, req_ready, exp_rdy);
        bad++;
      end else n_pass++;
      if (res_valid) begin
        n_chk++;
        if (!in_flight || res_id !== ID_W'(exp_id) || res_rem !== REM_W'(exp_word % DIV) ||
            res_div !== (exp_word % DIV == 0)) begin
          if (bad < 20) $display("FAIL rand_result: word=%0d id=%0d rem=%0d div=%b required %0d %0d %b",
                                 exp_word, res_id, res_rem, res_div, exp_id, exp_word % DIV, exp_word % DIV == 0);
          bad++;
        end else n_pass++;
        if (res_ready) begin res_took = 1; done_cnt++; end
      end
      if (g >= 0) begin
        in_flight = 1; exp_id = g; exp_word = wq[g];
        m_ptr = (g + 1) % N_REQ;
        v[g] = 1'b0;
      end
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    req_valid = '0;
    res_ready = 1'b0;
    n_chk++;
    if (done_cnt != 1000) $display("FAIL rand_completed: %0d results required 1000", done_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_result_stall();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
